// File: rtl/exp_golomb_sd_sequencer.sv
// Looks up a 16-bit exp-Golomb codeword for a 9-bit codeNum by reading one
// 512-byte table sector through an sd_controller and picking out two bytes.
module exp_golomb_sd_sequencer #(
    parameter int unsigned SECTOR_BASE    = 512,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        axiiv,
    input  logic [8:0]  axiid,
    output logic        axiir,
    input  logic        sd_ready,
    output logic        sd_rd,
    output logic [31:0] sd_addr,
    input  logic [7:0]  sd_dout,
    input  logic        sd_byte_available,
    output logic        axiov,
    output logic [15:0] axiod,
    output logic        err
);

    localparam int unsigned     TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [9:0]      CNT_FULL = 10'd512;
    localparam logic [31:0]     ADDR_LO  = 32'(SECTOR_BASE);
    localparam logic [31:0]     ADDR_HI  = 32'(SECTOR_BASE + 512);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_ISSUE,
        S_STREAM,
        S_FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [TMO_W-1:0] tmo_q;
    logic [9:0]       cnt_q;
    logic [8:0]       offset_q;
    logic             sd_rd_q;
    logic [31:0]      sd_addr_q;
    logic [15:0]      axiod_q;
    logic             err_q;

    logic             tmo_hit;
    logic             abort;
    logic             accept;
    logic             busy;
    logic             byte_ok;
    logic             cap_hi;
    logic             cap_lo;

    assign tmo_hit = (tmo_q == TMO_LAST);
    assign busy    = (state_q == S_WAIT_RDY) || (state_q == S_ISSUE) || (state_q == S_STREAM);
    assign byte_ok = (state_q == S_STREAM) && sd_byte_available && (cnt_q != CNT_FULL);
    assign cap_hi  = byte_ok && (cnt_q == {1'b0, offset_q});
    assign cap_lo  = byte_ok && (cnt_q == ({1'b0, offset_q} + 10'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A normal handshake step on the same cycle as the timeout wins over the abort.
    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        accept  = 1'b0;
        axiir   = 1'b0;
        axiov   = 1'b0;
        err     = 1'b0;
        case (state_q)
            S_IDLE: begin
                axiir = 1'b1;
                if (axiiv) begin
                    accept  = 1'b1;
                    state_d = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (sd_ready) begin
                    state_d = S_ISSUE;
                end else if (tmo_hit) begin
                    state_d = S_FINISH;
                    abort   = 1'b1;
                end
            end
            S_ISSUE: begin
                if (!sd_ready) begin
                    state_d = S_STREAM;
                end else if (tmo_hit) begin
                    state_d = S_FINISH;
                    abort   = 1'b1;
                end
            end
            S_STREAM: begin
                if (sd_ready) begin
                    state_d = S_FINISH;
                end else if (tmo_hit) begin
                    state_d = S_FINISH;
                    abort   = 1'b1;
                end
            end
            S_FINISH: begin
                axiov   = 1'b1;
                err     = err_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q     <= '0;
            cnt_q     <= '0;
            offset_q  <= '0;
            sd_rd_q   <= 1'b0;
            sd_addr_q <= '0;
            axiod_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if ((state_d != state_q) || !busy) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end

            // Read command is high exactly while the FSM sits in ISSUE.
            sd_rd_q <= (state_d == S_ISSUE);

            if (accept) begin
                sd_addr_q <= axiid[8] ? ADDR_HI : ADDR_LO;
                offset_q  <= {axiid[7:0], 1'b0};
                cnt_q     <= '0;
                axiod_q   <= '0;
                err_q     <= 1'b0;
            end else begin
                if (byte_ok) begin
                    cnt_q <= cnt_q + 10'd1;
                end
                if (abort) begin
                    axiod_q <= '0;
                    err_q   <= 1'b1;
                end else begin
                    if (cap_hi) begin
                        axiod_q[15:8] <= sd_dout;
                    end
                    if (cap_lo) begin
                        axiod_q[7:0] <= sd_dout;
                    end
                end
            end
        end
    end

    assign sd_rd   = sd_rd_q;
    assign sd_addr = sd_addr_q;
    assign axiod   = axiod_q;

endmodule
